multi_dac_model: RTL and testbench

MULTI_DAC_MODEL -- requirements
Module: multi_dac_model

---
 rtl/multi_dac_pkg.sv | 21 ++
 rtl/dac_channel.sv | 69 ++++++
 rtl/multi_dac_model.sv | 51 +++++
 tb/tb_multi_dac_model.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_dac_pkg.sv
// Shared types and the code-to-voltage transfer function for the multi-channel DAC model.
package multi_dac_pkg;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RAMP = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ch_state_e;

    // Ideal transfer: full-scale code maps exactly to vref.
    function automatic real code_to_volt(input int unsigned code,
                                         input int unsigned code_w,
                                         input real         vref);
        return real'(code) * vref / real'((32'd1 << code_w) - 32'd1);
    endfunction

endpackage

// File: rtl/dac_channel.sv
// One DAC channel: holds current/target code and slews toward the target in ramp mode.
module dac_channel
    import multi_dac_pkg::*;
#(
    parameter int CODE_W   = 12,
    parameter int STEP_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_mode,
    input  logic [CODE_W-1:0] i_code,
    output logic [CODE_W-1:0] o_code,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [CODE_W:0] STEP_LIM = (CODE_W + 1)'(STEP_MAX);

    logic [CODE_W-1:0] r_cur;
    logic [CODE_W-1:0] r_tgt;
    ch_state_e         r_state;
    logic              r_done;

    logic              w_up;
    logic [CODE_W:0]   w_dist;
    logic [CODE_W:0]   w_step;
    logic [CODE_W:0]   w_sum;

    // One extra bit keeps the distance and the stepped code free of wrap-around.
    assign w_up   = (r_tgt > r_cur);
    assign w_dist = w_up ? ({1'b0, r_tgt} - {1'b0, r_cur}) : ({1'b0, r_cur} - {1'b0, r_tgt});
    assign w_step = (w_dist > STEP_LIM) ? STEP_LIM : w_dist;
    assign w_sum  = w_up ? ({1'b0, r_cur} + w_step) : ({1'b0, r_cur} - w_step);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur   <= '0;
            r_tgt   <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                // A new command overrides this edge's ramp step and silently drops the old target.
                r_tgt <= i_code;
                if (mode_e'(i_mode) == MODE_STEP || i_code == r_cur) begin
                    r_cur   <= i_code;
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ST_RAMP;
                end
            end else if (r_state == ST_RAMP) begin
                r_cur <= w_sum[CODE_W-1:0];
                if (w_sum == {1'b0, r_tgt}) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign o_code = r_cur;
    assign o_busy = (r_state == ST_RAMP);
    assign o_done = r_done;

endmodule

// File: rtl/multi_dac_model.sv
// Multi-channel DAC behavioural model: decodes commands onto independent channels, outputs real voltages.
module multi_dac_model
    import multi_dac_pkg::*;
#(
    parameter  int  NUM_CH   = 4,
    parameter  int  CODE_W   = 12,
    parameter  real VREF     = 2.0,
    parameter  int  STEP_MAX = 16,
    localparam int  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [CODE_W-1:0] cmd_code,
    input  logic              cmd_mode,
    output real               vout [NUM_CH],
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    logic              w_accept;
    logic [NUM_CH-1:0] w_load;
    logic [CODE_W-1:0] w_code [NUM_CH];

    assign cmd_ready = ~rst;
    assign w_accept  = cmd_valid & cmd_ready;

    // Channel numbers with no instance match no decode line, so such commands are absorbed.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = w_accept && (cmd_ch == CH_W'(g));

        dac_channel #(
            .CODE_W   (CODE_W),
            .STEP_MAX (STEP_MAX)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[g]),
            .i_mode (cmd_mode),
            .i_code (cmd_code),
            .o_code (w_code[g]),
            .o_busy (busy[g]),
            .o_done (done[g])
        );

        assign vout[g] = code_to_volt(32'(w_code[g]), CODE_W, VREF);
    end

endmodule

// File: tb/tb_multi_dac_model.sv
// Directed self-checking bench for multi_dac_model (default build plus a 3-channel build for bad channels).
module tb_multi_dac_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_valid2;
    logic [1:0]  cmd_ch;
    logic [11:0] cmd_code;
    logic        cmd_mode;

    logic        cmd_ready;
    real         vout [4];
    logic [3:0]  busy;
    logic [3:0]  done;

    logic        cmd_ready2;
    real         vout2 [3];
    logic [2:0]  busy2;
    logic [2:0]  done2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_dac_model dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_code  (cmd_code),
        .cmd_mode  (cmd_mode),
        .vout      (vout),
        .busy      (busy),
        .done      (done)
    );

    multi_dac_model #(.NUM_CH(3)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid2),
        .cmd_ready (cmd_ready2),
        .cmd_ch    (cmd_ch),
        .cmd_code  (cmd_code),
        .cmd_mode  (cmd_mode),
        .vout      (vout2),
        .busy      (busy2),
        .done      (done2)
    );

    function automatic real volts(input int code);
        return real'(code) * 2.0 / 4095.0;
    endfunction

    function automatic real fabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Called right after a falling edge; returns 1 time unit after the accepting rising edge.
    task automatic send(input int ch, input int code, input bit mode, input bit to_dut2);
        cmd_ch     = 2'(ch);
        cmd_code   = 12'(code);
        cmd_mode   = mode;
        cmd_valid  = !to_dut2;
        cmd_valid2 = to_dut2;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
        cmd_ch     = '0;
        cmd_code   = '0;
        cmd_mode   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 0", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (vout[i] != 0.0) begin
                fails++;
                $display("FAIL reset_vout[%0d]: got %f expected 0.0", i, vout[i]);
            end
        end
        tests++;
        if (busy !== 4'b0 || done !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags: got busy=%b done=%b expected 0000/0000", busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_step_full();
        send(0, 4095, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (vout[0] != 2.0) begin
            fails++;
            $display("FAIL step_full_vout: got %f expected 2.0", vout[0]);
        end
        tests++;
        if (done !== 4'b0001 || busy !== 4'b0000) begin
            fails++;
            $display("FAIL step_full_done: got done=%b busy=%b expected 0001/0000", done, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 4'b0000) begin
            fails++;
            $display("FAIL step_full_done_once: got %b expected 0000", done);
        end
    endtask

    task automatic test_step_mid();
        send(1, 2048, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (fabs(vout[1] - volts(2048)) > 1e-9) begin
            fails++;
            $display("FAIL step_mid_vout: got %f expected %f", vout[1], volts(2048));
        end
        tests++;
        if (vout[2] != 0.0 || vout[3] != 0.0 || vout[0] != 2.0) begin
            fails++;
            $display("FAIL step_mid_others: got %f %f %f expected 2.0 0.0 0.0", vout[0], vout[2], vout[3]);
        end
        @(negedge clk);
    endtask

    task automatic test_ramp_up();
        int busy_cycles;
        int exp_code;
        send(2, 100, 1'b1, 1'b0);
        @(negedge clk);
        busy_cycles = busy[2] ? 1 : 0;
        tests++;
        if (vout[2] != 0.0 || busy !== 4'b0100 || done !== 4'b0000) begin
            fails++;
            $display("FAIL ramp_accept: got vout=%f busy=%b done=%b expected 0.0/0100/0000", vout[2], busy, done);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_code = (16 * k > 100) ? 100 : 16 * k;
            if (busy[2]) busy_cycles++;
            tests++;
            if (fabs(vout[2] - volts(exp_code)) > 1e-9 || done[2] !== (k == 7)) begin
                fails++;
                $display("FAIL ramp_step%0d: got vout=%f done=%b expected %f done=%0d",
                         k, vout[2], done[2], volts(exp_code), (k == 7));
            end
        end
        tests++;
        if (busy_cycles != 7) begin
            fails++;
            $display("FAIL ramp_busy_len: got %0d cycles expected 7", busy_cycles);
        end
        @(negedge clk);
        tests++;
        if (done !== 4'b0000 || busy !== 4'b0000) begin
            fails++;
            $display("FAIL ramp_end: got done=%b busy=%b expected 0000/0000", done, busy);
        end
    endtask

    task automatic test_retarget();
        int done_pulses = 0;
        int exp_code;
        send(3, 1000, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (done[3]) done_pulses++;
            tests++;
            if (fabs(vout[3] - volts(16 * k)) > 1e-9 || busy[3] !== 1'b1) begin
                fails++;
                $display("FAIL retarget_up%0d: got vout=%f busy=%b expected %f busy=1",
                         k, vout[3], busy[3], volts(16 * k));
            end
        end
        send(3, 0, 1'b1, 1'b0);
        @(negedge clk);
        if (done[3]) done_pulses++;
        tests++;
        if (fabs(vout[3] - volts(48)) > 1e-9 || busy[3] !== 1'b1) begin
            fails++;
            $display("FAIL retarget_hold: got vout=%f busy=%b expected %f busy=1", vout[3], busy[3], volts(48));
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (done[3]) done_pulses++;
            exp_code = 48 - 16 * k;
            tests++;
            if (fabs(vout[3] - volts(exp_code)) > 1e-9 || done[3] !== (k == 3)) begin
                fails++;
                $display("FAIL retarget_down%0d: got vout=%f done=%b expected %f done=%0d",
                         k, vout[3], done[3], volts(exp_code), (k == 3));
            end
        end
        @(negedge clk);
        if (done[3]) done_pulses++;
        tests++;
        if (done_pulses != 1 || busy[3] !== 1'b0) begin
            fails++;
            $display("FAIL retarget_done_count: got %0d pulses busy=%b expected 1 pulse busy=0", done_pulses, busy[3]);
        end
    endtask

    task automatic test_reset_mid_ramp();
        send(0, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if (busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL midramp_busy: got %b expected 1", busy[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (vout[0] != 0.0 || busy !== 4'b0000 || done !== 4'b0000 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL midramp_reset: got vout=%f busy=%b done=%b ready=%b expected 0.0/0000/0000/0",
                     vout[0], busy, done, cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 4'b0000 || busy !== 4'b0000) begin
            fails++;
            $display("FAIL midramp_release: got done=%b busy=%b expected 0000/0000", done, busy);
        end
        send(0, 10, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (fabs(vout[0] - volts(10)) > 1e-9 || done !== 4'b0001) begin
            fails++;
            $display("FAIL midramp_step10: got vout=%f done=%b expected %f done=0001", vout[0], done, volts(10));
        end
        @(negedge clk);
    endtask

    task automatic test_bad_channel();
        send(1, 2048, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (done2 !== 3'b010) begin
            fails++;
            $display("FAIL bad_ch_setup: got done=%b expected 010", done2);
        end
        @(negedge clk);
        tests++;
        if (cmd_ready2 !== 1'b1) begin
            fails++;
            $display("FAIL bad_ch_ready: got %b expected 1", cmd_ready2);
        end
        send(3, 4000, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (vout2[0] != 0.0 || fabs(vout2[1] - volts(2048)) > 1e-9 || vout2[2] != 0.0 ||
            busy2 !== 3'b000 || done2 !== 3'b000) begin
            fails++;
            $display("FAIL bad_ch_step: got %f %f %f busy=%b done=%b expected 0.0 %f 0.0 000/000",
                     vout2[0], vout2[1], vout2[2], busy2, done2, volts(2048));
        end
        send(3, 500, 1'b1, 1'b1);
        @(negedge clk);
        tests++;
        if (vout2[0] != 0.0 || fabs(vout2[1] - volts(2048)) > 1e-9 || vout2[2] != 0.0 ||
            busy2 !== 3'b000 || done2 !== 3'b000) begin
            fails++;
            $display("FAIL bad_ch_ramp: got %f %f %f busy=%b done=%b expected 0.0 %f 0.0 000/000",
                     vout2[0], vout2[1], vout2[2], busy2, done2, volts(2048));
        end
    endtask

    initial begin
        test_reset();
        test_step_full();
        test_step_mid();
        test_ramp_up();
        test_retarget();
        test_reset_mid_ramp();
        test_bad_channel();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
